// File: rtl/fixed_point_normalizer_pkg.sv
// Shared constants and the normalized-result bundle for the sin datapath.
// Used by the normalizer and the float packing stage that follows it.
package fixed_point_normalizer_pkg;

  localparam int WIDTH    = 10;
  localparam int POS_W    = 4;
  localparam int EXP_W    = 5;
  localparam int EXP_BIAS = 15;
  localparam int MAN_W    = 10;

  typedef struct packed {
    logic             zero;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } norm_t;

endpackage

// File: rtl/fixed_point_normalizer_norm_shifter.sv
// Combinational left barrel shifter: brings the leading one to the MSB.
// Ports: value/shamt in, man_full = value << shamt (same width as value).
module fixed_point_normalizer_norm_shifter #(
  parameter int WIDTH = 10,
  parameter int SH_W  = 4
) (
  input  logic [WIDTH-1:0] value,
  input  logic [SH_W-1:0]  shamt,
  output logic [WIDTH-1:0] man_full
);

  assign man_full = value << shamt;

endmodule

// File: rtl/fixed_point_normalizer.sv
// Two-stage fraction normalizer: lod -> biased exp + MSB-aligned mantissa.
// Ports: clock, reset (async active-low), io_in_* valid/ready/value/lod,
// io_out_* valid/ready/exp/man/zero; io_lod_err when
// FIXED_POINT_NORMALIZER_LOD_CHECK_EN is defined (sticky lod mismatch flag).
module fixed_point_normalizer #(
  parameter int WIDTH    = fixed_point_normalizer_pkg::WIDTH,
  parameter int POS_W    = fixed_point_normalizer_pkg::POS_W,
  parameter int EXP_W    = fixed_point_normalizer_pkg::EXP_W,
  parameter int EXP_BIAS = fixed_point_normalizer_pkg::EXP_BIAS,
  parameter int MAN_W    = fixed_point_normalizer_pkg::MAN_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_value,
  input  logic [POS_W-1:0] io_in_lod,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [EXP_W-1:0] io_out_exp,
  output logic [MAN_W-1:0] io_out_man,
  output logic             io_out_zero
`ifdef FIXED_POINT_NORMALIZER_LOD_CHECK_EN
  ,
  output logic             io_lod_err
`endif
);

  import fixed_point_normalizer_pkg::*;

  localparam int XW  = EXP_W + 2;
  localparam int PAD = MAN_W - (WIDTH - 1);

  logic             s1_valid;
  logic             s1_zero;
  logic [POS_W-1:0] s1_shamt;
  logic [EXP_W-1:0] s1_exp;
  logic [WIDTH-1:0] s1_value;
  logic             s2_valid;

  logic             s1_adv;
  logic             s2_adv;
  logic             in_fire;
  logic             in_zero;
  logic [POS_W-1:0] lod_c;
  logic [XW-1:0]    exp_wide;
  logic [WIDTH-1:0] man_full;
  logic [MAN_W-1:0] man;
  logic             unused_bits;

  assign s2_adv      = !s2_valid || io_out_ready;
  assign s1_adv      = s1_valid && s2_adv;
  assign io_in_ready = !s1_valid || s1_adv;
  assign in_fire     = io_in_valid && io_in_ready;
  assign in_zero     = (io_in_value == '0);

  // Out-of-range detector outputs are clamped so the shift stays defined.
  always_comb begin
    lod_c = io_in_lod;
    if (io_in_lod == '0) begin
      lod_c = POS_W'(1);
    end else if (io_in_lod > POS_W'(WIDTH)) begin
      lod_c = POS_W'(WIDTH);
    end
  end

  // EXP_BIAS + lod - 1 - WIDTH, wrapped to XW bits, truncated to EXP_W.
  assign exp_wide = XW'(EXP_BIAS) + XW'(lod_c) - XW'(WIDTH + 1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_zero  <= 1'b0;
      s1_shamt <= '0;
      s1_exp   <= '0;
      s1_value <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_zero  <= in_zero;
      s1_shamt <= in_zero ? '0 : POS_W'(WIDTH) - lod_c;
      s1_exp   <= in_zero ? '0 : exp_wide[EXP_W-1:0];
      s1_value <= io_in_value;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  fixed_point_normalizer_norm_shifter #(
    .WIDTH (WIDTH),
    .SH_W  (POS_W)
  ) u_shift (
    .value    (s1_value),
    .shamt    (s1_shamt),
    .man_full (man_full)
  );

  // Drop the hidden one, left-align the rest in the mantissa field.
  assign man = MAN_W'(man_full[WIDTH-2:0]) << PAD;

  assign unused_bits = ^{man_full[WIDTH-1], exp_wide[XW-1:EXP_W]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_valid    <= 1'b0;
      io_out_exp  <= '0;
      io_out_man  <= '0;
      io_out_zero <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        io_out_exp  <= s1_exp;
        io_out_man  <= s1_zero ? '0 : man;
        io_out_zero <= s1_zero;
      end
    end
  end

  assign io_out_valid = s2_valid;

`ifdef FIXED_POINT_NORMALIZER_LOD_CHECK_EN
  function automatic logic [POS_W-1:0] calc_lod(
    input logic [WIDTH-1:0] v
  );
    calc_lod = POS_W'(1);
    for (int i = 1; i < WIDTH; i++) begin
      if (v[i]) calc_lod = POS_W'(i + 1);
    end
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_lod_err <= 1'b0;
    end else if (in_fire && !in_zero &&
                 io_in_lod != calc_lod(io_in_value)) begin
      io_lod_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fixed_point_normalizer.sv
// Directed self-checking bench for fixed_point_normalizer.
// Covers latency, clamping, zero input, stalled streaming and reset flush.
module tb_fixed_point_normalizer;

  typedef struct packed {
    logic [9:0] value;
    logic [3:0] lod;
    logic [4:0] ex;
    logic [9:0] man;
    logic       zero;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       io_in_valid;
  logic       io_in_ready;
  logic [9:0] io_in_value;
  logic [3:0] io_in_lod;
  logic       io_out_valid;
  logic       io_out_ready;
  logic [4:0] io_out_exp;
  logic [9:0] io_out_man;
  logic       io_out_zero;
`ifdef FIXED_POINT_NORMALIZER_LOD_CHECK_EN
  logic       io_lod_err;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[9];
  logic pat[4];

  always #5 clock = ~clock;

  fixed_point_normalizer dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_value  (io_in_value),
    .io_in_lod    (io_in_lod),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_exp   (io_out_exp),
    .io_out_man   (io_out_man),
    .io_out_zero  (io_out_zero)
`ifdef FIXED_POINT_NORMALIZER_LOD_CHECK_EN
    ,
    .io_lod_err   (io_lod_err)
`endif
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic run_one(input int k);
    @(posedge clock); #1;
    io_in_valid  = 1'b1;
    io_in_value  = vecs[k].value;
    io_in_lod    = vecs[k].lod;
    io_out_ready = 1'b1;
    #1 check($sformatf("v%0d_in_ready", k), io_in_ready, 1);
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    check($sformatf("v%0d_lat1", k), io_out_valid, 0);
    @(posedge clock); #1;
    check($sformatf("v%0d_lat2", k), io_out_valid, 1);
    check($sformatf("v%0d_exp", k), io_out_exp, vecs[k].ex);
    check($sformatf("v%0d_man", k), io_out_man, vecs[k].man);
    check($sformatf("v%0d_zero", k), io_out_zero, vecs[k].zero);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int   sent;
    int   got;
    int   n;
    int   cyc;
    logic in_f;
    logic out_f;

    vecs[0] = '{10'h200, 4'd10, 5'd14, 10'h000, 1'b0};
    vecs[1] = '{10'h0C0, 4'd8,  5'd12, 10'h200, 1'b0};
    vecs[2] = '{10'h001, 4'd1,  5'd5,  10'h000, 1'b0};
    vecs[3] = '{10'h000, 4'd1,  5'd0,  10'h000, 1'b1};
    vecs[4] = '{10'h3FF, 4'd10, 5'd14, 10'h3FE, 1'b0};
    vecs[5] = '{10'h155, 4'd9,  5'd13, 10'h154, 1'b0};
    vecs[6] = '{10'h000, 4'd7,  5'd0,  10'h000, 1'b1};
    vecs[7] = '{10'h001, 4'd0,  5'd5,  10'h000, 1'b0};
    vecs[8] = '{10'h200, 4'd15, 5'd14, 10'h000, 1'b0};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    reset        = 1'b0;
    io_in_valid  = 1'b0;
    io_in_value  = '0;
    io_in_lod    = '0;
    io_out_ready = 1'b0;
    #12;
    check("rst_out_valid", io_out_valid, 0);
    check("rst_exp", io_out_exp, 0);
    check("rst_man", io_out_man, 0);
    check("rst_zero", io_out_zero, 0);
    check("rst_in_ready", io_in_ready, 1);
    @(negedge clock);
    reset = 1'b1;

    for (int k = 0; k < 7; k++) run_one(k);
`ifdef FIXED_POINT_NORMALIZER_LOD_CHECK_EN
    check("lod_err_clean", io_lod_err, 0);
`endif
    run_one(7);
    run_one(8);

    // Back-to-back stream with a stalling consumer.
    sent = 0;
    got  = 0;
    n    = 0;
    cyc  = 0;
    while (got < 6 && cyc < 80) begin
      @(posedge clock); #1;
      io_out_ready = pat[cyc % 4];
      io_in_valid  = (sent < 6);
      if (sent < 6) begin
        io_in_value = vecs[sent].value;
        io_in_lod   = vecs[sent].lod;
      end
      @(negedge clock);
      check("stream_in_ready", io_in_ready,
            32'(!(n == 2 && !io_out_ready)));
      in_f  = io_in_valid && io_in_ready;
      out_f = io_out_valid && io_out_ready;
      if (out_f) begin
        check($sformatf("s%0d_exp", got), io_out_exp, vecs[got].ex);
        check($sformatf("s%0d_man", got), io_out_man, vecs[got].man);
        check($sformatf("s%0d_zero", got), io_out_zero, vecs[got].zero);
        got++;
      end
      if (in_f) sent++;
      n = n + int'(in_f) - int'(out_f);
      cyc++;
    end
    check("stream_count", got, 6);
    @(posedge clock); #1;
    io_in_valid  = 1'b0;
    io_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("stream_no_dup", io_out_valid, 0);
    end

    // Fill both stages, stall, then reset mid-flight.
    @(posedge clock); #1;
    io_out_ready = 1'b0;
    io_in_valid  = 1'b1;
    io_in_value  = vecs[0].value;
    io_in_lod    = vecs[0].lod;
    @(posedge clock); #1;
    io_in_value = vecs[1].value;
    io_in_lod   = vecs[1].lod;
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    check("full_in_ready", io_in_ready, 0);
    check("full_out_valid", io_out_valid, 1);
    check("full_exp", io_out_exp, vecs[0].ex);
    @(posedge clock); #1;
    check("hold_out_valid", io_out_valid, 1);
    check("hold_exp", io_out_exp, vecs[0].ex);
    check("hold_in_ready", io_in_ready, 0);
    #2 reset = 1'b0;
    #1;
    check("arst_out_valid", io_out_valid, 0);
    check("arst_in_ready", io_in_ready, 1);
    check("arst_exp", io_out_exp, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    io_in_valid  = 1'b1;
    io_in_value  = vecs[1].value;
    io_in_lod    = vecs[1].lod;
    io_out_ready = 1'b1;
    check("post_rst_idle", io_out_valid, 0);
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    check("post_rst_lat1", io_out_valid, 0);
    @(posedge clock); #1;
    check("post_rst_lat2", io_out_valid, 1);
    check("post_rst_exp", io_out_exp, vecs[1].ex);
    check("post_rst_man", io_out_man, vecs[1].man);

`ifdef FIXED_POINT_NORMALIZER_LOD_CHECK_EN
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("lod_err_rst", io_lod_err, 0);
    @(posedge clock); #1;
    io_in_valid = 1'b1;
    io_in_value = 10'h0C0;
    io_in_lod   = 4'd5;
    #1 check("lod_err_pre", io_lod_err, 0);
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    check("lod_err_set", io_lod_err, 1);
    run_one(1);
    check("lod_err_sticky", io_lod_err, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fixed_point_normalizer.md
Name: fixed_point_normalizer

Overview:
- Stage directly downstream of the leading-one detector in the sin datapath.
- Takes an unsigned Q0.WIDTH fraction plus the detector's 1-based leading-one position, and produces a normalized half-precision-style exponent/mantissa pair.
- Two-stage pipeline with valid/ready handshake at both ends; feeds the float packing stage.

Parameters:
- WIDTH, 10, fraction input width (matches detector input width).
- POS_W, 4, width of leading-one position input; must hold value WIDTH.
- EXP_W, 5, output exponent width.
- EXP_BIAS, 15, exponent bias.
- MAN_W, 10, output mantissa width (hidden one dropped); requires MAN_W >= WIDTH-1.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low (asserted when 0); one clock, reset is asynchronous and active-low.
- io_in_valid  input  1  upstream data valid.
- io_in_ready  output  1  stage accepts data this cycle.
- io_in_value  input  WIDTH  unsigned fraction, value = io_in_value / 2^WIDTH.
- io_in_lod  input  POS_W  detector output: 1 + index of highest set bit; 1 when the value is 0 or only bit0 is set.
- io_out_valid  output  1  result valid.
- io_out_ready  input  1  downstream accepts.
- io_out_exp  output  EXP_W  biased exponent.
- io_out_man  output  MAN_W  mantissa bits below the hidden one, MSB-aligned.
- io_out_zero  output  1  input value was zero.

Behaviour:
- Reset (async assert): s1_valid=0, s2_valid=0, io_out_valid=0, io_out_exp=0, io_out_man=0, io_out_zero=0. Data registers clear to 0. Release is sampled synchronously at the next clock edge.
- Transfer rule: a transfer occurs when valid&&ready on the same rising edge. Data is held stable while valid && !ready.
- Stage 1, on input transfer, registers:
  - zero = (io_in_value==0)
  - shamt = WIDTH - io_in_lod
  - exp = EXP_BIAS + io_in_lod - 1 - WIDTH, computed at EXP_W+2 bits signed and truncated to EXP_W
  - value
- Stage 2: man_full = value << shamt (WIDTH bits, leading one now at bit WIDTH-1). The mantissa is man_full[WIDTH-2:0] followed by MAN_W-(WIDTH-1) zero LSBs.
- Zero input: exp=0, man=0, zero=1. io_in_lod is ignored.
- io_in_lod > WIDTH or io_in_lod == 0: treated as WIDTH and 1 respectively (clamped). No X propagation.
- Pipeline control:
  - s2 advances when !s2_valid || io_out_ready.
  - s1 advances into s2 when s1_valid && s2 advances.
  - io_in_ready = !s1_valid || s1 advances (combinational from io_out_ready, no skid buffer).
- Latency: 2 cycles from input transfer to io_out_valid with no stall. Throughput is 1 per cycle under continuous ready.
- Simultaneous input and output transfer in one cycle: both stages shift. No bubble, no data loss.
- Output stall with both stages full: io_in_ready=0. Contents are held.
- Reset mid-operation discards all in-flight data. No output is produced for it.

Optional Feature:
- Macro: FIXED_POINT_NORMALIZER_LOD_CHECK_EN.
- When defined:
  - Stage 1 recomputes the leading-one position from io_in_value.
  - Adds port io_lod_err (output, 1).
  - io_lod_err is a sticky register, set on any accepted input whose io_in_lod mismatches the recomputed position (non-zero values only).
  - Cleared only by reset.
  - The data path still uses io_in_lod.
- When undefined: no port, no check logic.

Decomposition:
- Shared package holds:
  - constants WIDTH, EXP_W, EXP_BIAS, MAN_W
  - a typedef for the normalized result {zero, exp, man}, reused by the packing stage.
- One natural sub-module: norm_shifter, a combinational left barrel shifter (value, shamt -> man_full) instantiated in stage 2.

Test Plan:
- value=10'h200, lod=10, ready=1 -> after 2 cycles exp=14, man=10'h000, zero=0.
- value=10'h0C0, lod=8 -> exp=12, man=10'h200.
- value=10'h001, lod=1 -> exp=5, man=10'h000. Then value=0, lod=1 -> zero=1, exp=0, man=0.
- Stream 6 back-to-back inputs with io_out_ready toggled 1,0,0,1,… -> all 6 results in order, none duplicated. io_in_ready=0 only while both stages are full.
- Assert reset (0) with both stages valid -> io_out_valid drops immediately. After release, the next input appears after exactly 2 cycles.
- With FIXED_POINT_NORMALIZER_LOD_CHECK_EN: value=10'h0C0, lod=5 -> io_lod_err=1 one cycle after transfer and stays 1 until reset. Correct inputs never set it.
